ex_mem_skid_stage: RTL and testbench
====================================

Name: ex_mem_skid_stage

Overview:
Pipeline stage directly downstream of the 64-bit ALU. It registers the ALU Result/ZERO pair together with the memory/writeback control bits, and resolves branch-taken and branch-target for the fetch stage. A 2-entry skid buffer with a valid/ready handshake on both sides absorbs a memory-stage stall without a combinational ready path back into EX.

Parameters:
DATA_W, 64, width of ALU result, PC, immediate and store data
RD_W, 5, destination register index width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  EX presents a valid instruction
in_ready  output  1  stage can accept this cycle
alu_result  input  DATA_W  ALU Result
zero  input  1  ALU ZERO (already funct3-qualified by the ALU)
pc  input  DATA_W  PC of the instruction
imm  input  DATA_W  sign-extended immediate
rs2_data  input  DATA_W  store data
rd  input  RD_W  destination register
branch, mem_read, mem_write, reg_write, mem_to_reg  input  1 each  control bits
flush  input  1  kill all held entries
out_valid  output  1  entry presented to MEM
out_ready  input  1  MEM accepts
out_alu_result  output  DATA_W  registered ALU result
out_write_data  output  DATA_W  registered rs2_data
out_rd  output  RD_W  registered rd
out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg  output  1 each  registered control, forced 0 when out_valid=0
out_branch_taken  output  1  branch & zero of presented entry, 0 when out_valid=0
out_branch_target  output  DATA_W  pc + (imm << 1), modulo 2^DATA_W

Behaviour:
- Storage: main entry (drives outputs) and skid entry. States: EMPTY, ONE (main valid), TWO (main+skid valid).
- in_ready = (state != TWO); registered-state-only, no combinational dependence on out_ready.
- Accept = in_valid & in_ready; pop = out_valid & out_ready.
- EMPTY: accept -> load main, go ONE. Input-to-output latency is 1 cycle.
- ONE: accept & pop -> main reloaded from input, stay ONE; accept only -> load skid, go TWO; pop only -> EMPTY.
- TWO: pop -> skid moves to main, skid cleared, go ONE; no pop -> hold. in_ready=0, so inputs are ignored.
- Ordering is strict FIFO; no entry is duplicated or dropped except by flush/reset.
- Branch target and taken are computed at capture and stored per entry, so they are stable while held.
- Target arithmetic: imm shifted left 1 within DATA_W bits; sum truncated to DATA_W (wrap, no error).
- flush=1: next state EMPTY and both entries are invalidated. Same-cycle in_valid is dropped. Same-cycle pop is irrelevant (entry discarded). out_valid=0 the following cycle.
- reset=1 (sampled on clk): state EMPTY. All outputs 0 the next cycle: out_valid, all control bits, out_branch_taken, out_alu_result, out_write_data, out_rd, out_branch_target. Reset overrides flush and in_valid; reset mid-stall discards both entries.
- While out_valid=0, data outputs may hold stale values, but control bits and out_branch_taken are gated to 0.
- in_ready is 1 in the cycle after reset.
- Data outputs must not change while out_valid=1 and out_ready=0.

Test Plan:
- Reset, then in_valid=1, alu_result=64'h10, zero=1, branch=1, pc=64'h100, imm=64'h8, out_ready=1 -> next cycle out_valid=1, out_alu_result=64'h10, out_branch_taken=1, out_branch_target=64'h110.
- out_ready=0, three back-to-back inputs A,B,C -> A and B accepted; in_ready=0 when C is offered. Then raise out_ready -> outputs A then B on consecutive cycles; C is accepted once in_ready returns, order A,B,C preserved.
- Branch with zero=0 -> out_branch_taken=0 and control bits passed through. With out_valid=0 -> all control outputs are 0.
- pc=64'hFFFF_FFFF_FFFF_FFF0, imm=64'h10 -> out_branch_target=64'h0000_0000_0000_0010 (wrap).
- State TWO, assert flush with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed entries and the same-cycle input never appear.
- Assert reset while in state TWO with flush=1 -> next cycle all outputs 0 and in_ready=1; the first new input appears after 1 cycle.

Source files
------------

// File: rtl/ex_mem_skid_stage.sv
// rtl/ex_mem_skid_stage.sv - EX/MEM pipeline register with 2-entry skid buffer and branch resolve
//
// Purpose:
//   Registers the ALU result/ZERO pair and the memory/writeback control bits
//   coming out of EX, resolving branch-taken and branch-target at capture time.
//   A main entry drives the outputs; a skid entry absorbs one extra instruction
//   when MEM stalls, so in_ready depends on registered state only.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   - EX-side handshake
//   alu_result, zero, pc, imm, rs2_data, rd,
//   branch, mem_read, mem_write, reg_write, mem_to_reg - instruction fields from EX
//   flush                 - discard every held entry and the same-cycle input
//   out_valid / out_ready - MEM-side handshake
//   out_*                 - presented entry; control bits and branch_taken gated by out_valid

module ex_mem_skid_stage #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              zero,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [RD_W-1:0]   rd,
  input  logic              branch,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_write_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic              out_branch_taken,
  output logic [DATA_W-1:0] out_branch_target
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] branch_target;
    logic [RD_W-1:0]   rd;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic              branch_taken;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   accept;
  logic   pop;

  // Branch outcome is resolved here so a held entry never recomputes it.
  always_comb begin
    in_entry               = '0;
    in_entry.alu_result    = alu_result;
    in_entry.write_data    = rs2_data;
    in_entry.branch_target = pc + (imm << 1);
    in_entry.rd            = rd;
    in_entry.mem_read      = mem_read;
    in_entry.mem_write     = mem_write;
    in_entry.reg_write     = reg_write;
    in_entry.mem_to_reg    = mem_to_reg;
    in_entry.branch_taken  = branch & zero;
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_d = in_entry;
        end else if (accept) begin
          // Main is stalled; keep it untouched so outputs stay stable.
          skid_d  = in_entry;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Entries become unreachable once state is EMPTY; their data may stay stale.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_alu_result    = main_q.alu_result;
  assign out_write_data    = main_q.write_data;
  assign out_rd            = main_q.rd;
  assign out_branch_target = main_q.branch_target;
  assign out_mem_read      = out_valid & main_q.mem_read;
  assign out_mem_write     = out_valid & main_q.mem_write;
  assign out_reg_write     = out_valid & main_q.reg_write;
  assign out_mem_to_reg    = out_valid & main_q.mem_to_reg;
  assign out_branch_taken  = out_valid & main_q.branch_taken;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb/tb_ex_mem_skid_stage.sv - bench for ex_mem_skid_stage against a FIFO-queue reference

module tb_ex_mem_skid_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, zero, flush, out_valid, out_ready;
  logic [63:0] alu_result, pc, imm, rs2_data;
  logic [4:0]  rd;
  logic        branch, mem_read, mem_write, reg_write, mem_to_reg;
  logic [63:0] out_alu_result, out_write_data, out_branch_target;
  logic [4:0]  out_rd;
  logic        out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, out_branch_taken;

  always #5 clk = ~clk;

  ex_mem_skid_stage #(.DATA_W(64), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .zero(zero), .pc(pc), .imm(imm), .rs2_data(rs2_data), .rd(rd),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_write_data(out_write_data), .out_rd(out_rd),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
    .out_mem_to_reg(out_mem_to_reg), .out_branch_taken(out_branch_taken),
    .out_branch_target(out_branch_target)
  );

  typedef struct {
    logic [63:0] alu, wd, tgt;
    logic [4:0]  rd;
    logic        mr, mw, rw, m2r, taken;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   zero_expect = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk();
    exp_t e;
    e.alu   = alu_result;
    e.wd    = rs2_data;
    e.tgt   = pc + (imm * 64'd2);
    e.rd    = rd;
    e.mr    = mem_read;
    e.mw    = mem_write;
    e.rw    = reg_write;
    e.m2r   = mem_to_reg;
    e.taken = branch && zero;
    return e;
  endfunction

  // Apply the currently driven inputs to the queue model, then compare after the edge.
  task automatic tick();
    bit do_pop, do_acc;
    exp_t e;
    e = mk();
    zero_expect = reset;
    if (reset || flush) begin
      q.delete();
    end else begin
      do_pop = (q.size() != 0) && out_ready;
      do_acc = in_valid && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_acc) q.push_back(e);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_outputs();
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("alu_result", out_alu_result, q[0].alu);
      chk("write_data", out_write_data, q[0].wd);
      chk("rd", {59'd0, out_rd}, {59'd0, q[0].rd});
      chk("target", out_branch_target, q[0].tgt);
      chk("ctrl", {59'd0, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, out_branch_taken},
          {59'd0, q[0].mr, q[0].mw, q[0].rw, q[0].m2r, q[0].taken});
    end else begin
      chk("ctrl_gated", {59'd0, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, out_branch_taken}, 64'd0);
      if (zero_expect) begin
        chk("rst_alu", out_alu_result, 64'd0);
        chk("rst_wd", out_write_data, 64'd0);
        chk("rst_rd", {59'd0, out_rd}, 64'd0);
        chk("rst_tgt", out_branch_target, 64'd0);
      end
    end
  endtask

  task automatic rand_fields();
    alu_result = {$urandom, $urandom};
    pc         = {$urandom, $urandom};
    imm        = {$urandom, $urandom};
    rs2_data   = {$urandom, $urandom};
    rd         = 5'($urandom);
    zero       = 1'($urandom);
    branch     = 1'($urandom);
    mem_read   = 1'($urandom);
    mem_write  = 1'($urandom);
    reg_write  = 1'($urandom);
    mem_to_reg = 1'($urandom);
  endtask

  initial begin
    rand_fields();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    tick();
    // Directed: first instruction through, latency one cycle
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk("ready_after_reset", {63'd0, in_ready}, 64'd1);
    rand_fields();
    in_valid = 1'b1; alu_result = 64'h10; zero = 1'b1; branch = 1'b1;
    pc = 64'h100; imm = 64'h8; out_ready = 1'b1;
    tick();
    chk("tp1_valid", {63'd0, out_valid}, 64'd1);
    chk("tp1_alu", out_alu_result, 64'h10);
    chk("tp1_taken", {63'd0, out_branch_taken}, 64'd1);
    chk("tp1_tgt", out_branch_target, 64'h110);
    in_valid = 1'b0;
    tick();
    // Stall with A, B, C back-to-back; C is held until in_ready returns
    out_ready = 1'b0; in_valid = 1'b1;
    rand_fields(); alu_result = 64'hA; tick();
    rand_fields(); alu_result = 64'hB; tick();
    rand_fields(); alu_result = 64'hC;
    chk("stall_not_ready", {63'd0, in_ready}, 64'd0);
    tick();
    out_ready = 1'b1;
    tick();
    chk("order_b", out_alu_result, 64'hB);
    tick();
    chk("order_c", out_alu_result, 64'hC);
    in_valid = 1'b0;
    tick();
    // Branch not taken; controls pass through
    rand_fields(); in_valid = 1'b1; branch = 1'b1; zero = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; mem_to_reg = 1'b1;
    tick();
    chk("nt_taken", {63'd0, out_branch_taken}, 64'd0);
    // Target wrap
    rand_fields(); pc = 64'hFFFF_FFFF_FFFF_FFF0; imm = 64'h10;
    tick();
    chk("wrap_tgt", out_branch_target, 64'h0000_0000_0000_0010);
    in_valid = 1'b0;
    tick();
    // Flush from TWO with a same-cycle input
    out_ready = 1'b0; in_valid = 1'b1;
    rand_fields(); tick();
    rand_fields(); tick();
    rand_fields(); flush = 1'b1;
    tick();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_ready", {63'd0, in_ready}, 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    // Reset while in TWO with flush, then a fresh input
    in_valid = 1'b1;
    rand_fields(); tick();
    rand_fields(); tick();
    rand_fields(); reset = 1'b1; flush = 1'b1;
    tick();
    chk("rst2_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    rand_fields(); alu_result = 64'h5A5A;
    tick();
    chk("rst2_first", out_alu_result, 64'h5A5A);
    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 79) == 0);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
